sram_stack_ctrl: RTL and testbench

//  Bus initiator that drives the single-port data SRAM (0x0100..0x08FF) for the ATmega328PB core.

---
 rtl/sram_stack_ctrl_pkg.sv | 34 +++
 rtl/sram_stack_ctrl_sp.sv | 31 +++
 rtl/sram_stack_ctrl.sv | 103 ++++++++++
 tb/tb_sram_stack_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_stack_ctrl_pkg.sv
// sram_stack_ctrl_pkg: shared constants, command/state encodings and command helpers for the SRAM stack controller
package sram_stack_ctrl_pkg;
    localparam logic [15:0] RAM_START = 16'h0100;
    localparam logic [15:0] RAM_END   = 16'h08FF;
    localparam logic [15:0] SP_RST    = 16'h08FF;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_LOAD, CMD_STORE, CMD_PUSH8, CMD_POP8, CMD_PUSH16, CMD_POP16
    } cmd_e;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_e;

    typedef enum logic [2:0] {SP_HOLD, SP_INC1, SP_DEC1, SP_INC2, SP_DEC2} sp_op_e;

    function automatic logic in_ram(input logic [15:0] a);
        return a >= RAM_START && a <= RAM_END;
    endfunction

    function automatic logic is_rd(input cmd_e c);
        return c inside {CMD_LOAD, CMD_POP8, CMD_POP16};
    endfunction

    function automatic logic is_16(input cmd_e c);
        return c inside {CMD_PUSH16, CMD_POP16};
    endfunction

    function automatic logic is_push(input cmd_e c);
        return c inside {CMD_PUSH8, CMD_PUSH16};
    endfunction

    function automatic logic is_stack(input cmd_e c);
        return c inside {CMD_PUSH8, CMD_POP8, CMD_PUSH16, CMD_POP16};
    endfunction
endpackage

// File: rtl/sram_stack_ctrl_sp.sv
// sram_stack_ctrl_sp: 16-bit stack pointer with SPL/SPH byte writes and modulo +-1/+-2 adjustment
module sram_stack_ctrl_sp
    import sram_stack_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  we,
    input  logic [7:0]  wdata,
    input  sp_op_e      op,
    output logic [15:0] sp
);
    logic [15:0] delta;

    // signed step expressed as a 16-bit modulo addend
    always_comb begin
        delta = op == SP_INC1 ? 16'h0001 :
                op == SP_DEC1 ? 16'hFFFF :
                op == SP_INC2 ? 16'h0002 :
                op == SP_DEC2 ? 16'hFFFE : 16'h0000;
    end

    // byte writes take priority; otherwise apply the step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= SP_RST;
        else if (|we)
            sp <= {we[1] ? wdata : sp[15:8], we[0] ? wdata : sp[7:0]};
        else
            sp <= sp + delta;
    end
endmodule

// File: rtl/sram_stack_ctrl.sv
// sram_stack_ctrl: data-space initiator for the SRAM handling load/store, 8/16-bit push/pop and range checks
module sram_stack_ctrl
    import sram_stack_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  cmd,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  sp_we,
    input  logic [7:0]  sp_wdata,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [15:0] sp,
    output logic        sram_we,
    output logic        sram_re,
    output logic [11:0] sram_addr,
    output logic [7:0]  sram_di,
    input  logic [7:0]  sram_dout
);
    state_e      state, state_n;
    cmd_e        cmd_q, cmd_n, c_in;
    sp_op_e      sp_op;
    logic [15:0] a_q, a_n, a_pick, rd_n;
    logic [7:0]  hi_q, hi_n, b, di_n;
    logic [11:0] addr_n;
    logic        bad_q, bad_n, any_q, any_n;
    logic        accept, launch, fin, rd_cmd, ok, we_n, re_n, done_n, err_n;

    sram_stack_ctrl_sp u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (state == IDLE ? sp_we : 2'b00),
        .wdata (sp_wdata),
        .op    (sp_op),
        .sp    (sp)
    );

    assign busy = state != IDLE;

    // next state, byte address selection, strobe launch and completion
    always_comb begin
        c_in    = cmd_e'(cmd);
        accept  = req && state == IDLE && sp_we == 2'b00 && cmd != 3'd0 && cmd != 3'd7;
        launch  = (state == IDLE && accept) || (state == ACC1 && is_16(cmd_q));
        fin     = (state == ACC1 && !is_16(cmd_q)) || state == ACC2;
        rd_cmd  = state == IDLE ? is_rd(c_in) : is_rd(cmd_q);
        a_pick  = state == IDLE ? (is_stack(c_in) ? (is_push(c_in) ? sp : sp + 16'd1) : addr)
                                : (is_push(cmd_q) ? a_q - 16'd1 : a_q + 16'd1);
        ok      = in_ram(a_pick);
        b       = bad_q ? 8'h00 : sram_dout;
        state_n = state == IDLE ? (accept ? ACC1 : IDLE) : (state == ACC1 && is_16(cmd_q)) ? ACC2 : IDLE;
        cmd_n   = accept ? c_in : cmd_q;
        a_n     = launch ? a_pick : a_q;
        hi_n    = state == IDLE ? wdata[15:8] : state == ACC1 ? b : hi_q;
        bad_n   = launch ? !ok : bad_q;
        any_n   = state == IDLE ? !ok : any_q | (launch & !ok);
        we_n    = launch && ok && !rd_cmd;
        re_n    = launch && ok && rd_cmd;
        addr_n  = launch ? a_pick[11:0] : sram_addr;
        di_n    = launch ? (state == IDLE ? wdata[7:0] : hi_q) : sram_di;
        done_n  = fin;
        err_n   = (req && !accept) || (fin && any_q);
        rd_n    = fin && is_rd(cmd_q) ? (state == ACC2 ? {hi_q, b} : {8'h00, b}) : rd_data;
        sp_op   = state != IDLE && is_stack(cmd_q) ? (is_push(cmd_q) ? SP_DEC1 : SP_INC1) : SP_HOLD;
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= CMD_NOP;
            a_q       <= '0;
            hi_q      <= '0;
            bad_q     <= 1'b0;
            any_q     <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            sram_addr <= '0;
            sram_di   <= '0;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_n;
            a_q       <= a_n;
            hi_q      <= hi_n;
            bad_q     <= bad_n;
            any_q     <= any_n;
            rd_data   <= rd_n;
            done      <= done_n;
            err       <= err_n;
            sram_we   <= we_n;
            sram_re   <= re_n;
            sram_addr <= addr_n;
            sram_di   <= di_n;
        end
    end
endmodule

// File: tb/tb_sram_stack_ctrl.sv
// tb_sram_stack_ctrl: randomized self-checking bench for sram_stack_ctrl against a byte-level stack/memory model
module tb_sram_stack_ctrl;
    logic        clk, rst_n, req;
    logic [2:0]  cmd;
    logic [15:0] addr, wdata, rd_data, sp;
    logic [1:0]  sp_we;
    logic [7:0]  sp_wdata, sram_di, sram_dout;
    logic        done, busy, err, sram_we, sram_re;
    logic [11:0] sram_addr;

    logic [7:0]  sram [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [15:0] m_sp, m_rd;
    int          checks, fails;

    sram_stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .sp_we(sp_we), .sp_wdata(sp_wdata), .rd_data(rd_data), .done(done), .busy(busy),
        .err(err), .sp(sp), .sram_we(sram_we), .sram_re(sram_re), .sram_addr(sram_addr),
        .sram_di(sram_di), .sram_dout(sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: samples strobes on negedge, updates read data on negedge
    always @(negedge clk) begin
        if (sram_we) sram[sram_addr] <= sram_di;
        if (sram_re) sram_dout <= sram[sram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ok_addr(input logic [15:0] a);
        return a >= 16'h0100 && a <= 16'h08FF;
    endfunction

    task automatic put(input logic [15:0] p, input logic [7:0] v, inout int n, inout logic e);
        if (ok_addr(p)) begin ref_mem[p[11:0]] = v; n++; end else e = 1'b1;
    endtask

    task automatic get(input logic [15:0] p, output logic [7:0] v, inout int n, inout logic e);
        if (ok_addr(p)) begin v = ref_mem[p[11:0]]; n++; end else begin v = 8'h00; e = 1'b1; end
    endtask

    task automatic mem_cmp(input string tag);
        int bad = 0;
        for (int i = 0; i < 4096; i++) if (sram[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // starts and ends on a negedge; optional extra req while busy must be dropped
    task automatic run_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] w, input bit extra);
        int lat, nw, nr, nwe, nre, both;
        logic e;
        logic [7:0] hb, lb;
        lat = (c == 3'd5 || c == 3'd6) ? 3 : 2;
        e = 1'b0; nw = 0; nr = 0; nwe = 0; nre = 0; both = 0;
        case (c)
            3'd1: begin get(a, lb, nr, e); m_rd = {8'h00, lb}; end
            3'd2: put(a, w[7:0], nw, e);
            3'd3: begin put(m_sp, w[7:0], nw, e); m_sp = m_sp - 16'd1; end
            3'd4: begin m_sp = m_sp + 16'd1; get(m_sp, lb, nr, e); m_rd = {8'h00, lb}; end
            3'd5: begin put(m_sp, w[7:0], nw, e); put(m_sp - 16'd1, w[15:8], nw, e); m_sp = m_sp - 16'd2; end
            default: begin
                get(m_sp + 16'd1, hb, nr, e); get(m_sp + 16'd2, lb, nr, e);
                m_sp = m_sp + 16'd2; m_rd = {hb, lb};
            end
        endcase
        req = 1'b1; cmd = c; addr = a; wdata = w; sp_we = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req = (k == 1) && extra;
            cmd = (k == 1 && extra) ? 3'd1 : 3'd0;
            nwe += int'(sram_we); nre += int'(sram_re); both += int'(sram_we && sram_re);
            chk("done", done, k == lat);
            chk("busy", busy, k < lat);
            chk("err", err, (k == lat && e) || (k == 2 && extra));
            if (k == lat) begin
                chk("rd_data", rd_data, m_rd);
                chk("sp", sp, m_sp);
            end
        end
        chk("we_pulses", nwe, nw);
        chk("re_pulses", nre, nr);
        chk("we_re_overlap", both, 0);
    endtask

    task automatic set_sp(input logic [1:0] we, input logic [7:0] d);
        sp_we = we; sp_wdata = d;
        @(negedge clk);
        sp_we = 2'b00;
        if (we[0]) m_sp[7:0] = d;
        if (we[1]) m_sp[15:8] = d;
        chk("sp_write", sp, m_sp);
    endtask

    task automatic set_sp16(input logic [15:0] v);
        set_sp(2'b10, v[15:8]);
        set_sp(2'b01, v[7:0]);
    endtask

    task automatic drop_req(input logic [2:0] c, input logic [1:0] we, input logic [7:0] d);
        req = 1'b1; cmd = c; addr = 16'h0200; sp_we = we; sp_wdata = d;
        @(negedge clk);
        req = 1'b0; cmd = 3'd0; sp_we = 2'b00;
        if (we[0]) m_sp[7:0] = d;
        if (we[1]) m_sp[15:8] = d;
        chk("drop_err", err, 1);
        chk("drop_done", done, 0);
        chk("drop_strobe", {sram_we, sram_re}, 0);
        chk("drop_sp", sp, m_sp);
        @(negedge clk);
        chk("drop_err_end", err, 0);
        chk("drop_strobe2", {sram_we, sram_re}, 0);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 16'h00FF;
            1: return 16'h0100;
            2: return 16'h08FF;
            3: return 16'h0900;
            4: return 16'($urandom);
            default: return 16'($urandom_range(16'h0100, 16'h08FF));
        endcase
    endfunction

    function automatic logic [15:0] pick_sp();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h0100;
            3: return 16'h0101;
            4: return 16'h00FF;
            5: return 16'h0900;
            6: return 16'h08FE;
            default: return 16'($urandom_range(16'h0180, 16'h0880));
        endcase
    endfunction

    initial begin
        checks = 0; fails = 0;
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        sram_dout = 8'h00;
        rst_n = 1'b0; req = 1'b0; cmd = 3'd0; addr = '0; wdata = '0; sp_we = 2'b00; sp_wdata = '0;
        m_sp = 16'h08FF; m_rd = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_sp", sp, 16'h08FF);
        chk("rst_outs", {rd_data, done, busy, err, sram_we, sram_re, sram_addr, sram_di}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_strobe", {sram_we, sram_re, done, err, busy}, 0);
        end
        chk("idle_sp", sp, 16'h08FF);

        run_op(3'd2, 16'h0100, 16'h00A5, 0);
        run_op(3'd1, 16'h0100, 16'h0000, 0);
        chk("load_a5", rd_data, 16'h00A5);

        run_op(3'd5, 16'h0000, 16'h1234, 0);
        chk("push16_lo", sram[12'h8FF], 8'h34);
        chk("push16_hi", sram[12'h8FE], 8'h12);
        run_op(3'd6, 16'h0000, 16'h0000, 0);
        chk("pop16_val", rd_data, 16'h1234);

        run_op(3'd1, 16'h00FF, 16'h0000, 0);
        run_op(3'd2, 16'h0900, 16'h005A, 0);
        mem_cmp("mem_oor");

        run_op(3'd3, 16'h0000, 16'h0077, 1);
        drop_req(3'd1, 2'b01, 8'hFE);
        drop_req(3'd0, 2'b00, 8'h00);
        set_sp(2'b01, 8'h80);
        chk("spl_80", sp, 16'h0880);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) set_sp16(pick_sp());
            else if ($urandom_range(0, 19) == 0) drop_req(3'($urandom_range(1, 6)), 2'($urandom_range(1, 3)), 8'($urandom));
            else run_op(3'($urandom_range(1, 6)), pick_addr(), 16'($urandom), $urandom_range(0, 7) == 0);
            if (n % 50 == 49) mem_cmp("mem_rand");
        end

        set_sp16(16'h08FF);
        req = 1'b1; cmd = 3'd5; wdata = 16'hBEEF;
        @(negedge clk);
        req = 1'b0; cmd = 3'd0;
        @(posedge clk);
        #1;
        chk("acc2_we", sram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop", {sram_we, sram_re, busy, done}, 0);
        chk("rst_sp_mid", sp, 16'h08FF);
        ref_mem[12'h8FF] = 8'hEF;
        m_sp = 16'h08FF; m_rd = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_lo", sram[12'h8FF], 8'hEF);
        mem_cmp("mem_rst");
        chk("rst_sp_after", sp, m_sp);
        chk("rst_rd", rd_data, m_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
